// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: clears the back bank, lets the renderer draw one frame into it,
// and exchanges front/back banks on the first vblank after the frame is finished.
module fb_swap_controller #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter bit CLEAR_VALUE       = 1'b0,
  localparam int PIXELS           = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int AW               = $clog2(PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          frame_start,
  input  logic          rend_wr_en,
  input  logic [AW-1:0] rend_wr_addr,
  input  logic          rend_wr_data,
  input  logic          rend_done,
  output logic          swap,
  output logic          fb_wr_en,
  output logic [AW:0]   fb_wr_addr,
  output logic          fb_wr_data,
  output logic          disp_bank,
  output logic [7:0]    overruns
);

  typedef enum logic [1:0] {
    CLEAR       = 2'd0,
    RENDER      = 2'd1,
    WAIT_VBLANK = 2'd2,
    SWAP        = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;

  // Strobes default low every cycle; the back bank is always the complement of disp_bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      disp_bank  <= 1'b0;
      swap       <= 1'b0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= 1'b0;
      overruns   <= 8'd0;
    end else begin
      swap     <= 1'b0;
      fb_wr_en <= 1'b0;
      if (ce) begin
        case (state)
          CLEAR: begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= {~disp_bank, clr_cnt};
            fb_wr_data <= CLEAR_VALUE;
            if (clr_cnt == AW'(PIXELS - 1)) begin
              clr_cnt <= '0;
              swap    <= 1'b1;
              state   <= RENDER;
            end else begin
              clr_cnt <= clr_cnt + AW'(1);
            end
          end
          RENDER: begin
            fb_wr_en   <= rend_wr_en;
            fb_wr_addr <= {~disp_bank, rend_wr_addr};
            fb_wr_data <= rend_wr_data;
            if (rend_done) begin
              state <= frame_start ? SWAP : WAIT_VBLANK;
            end else if (frame_start && overruns != 8'hFF) begin
              overruns <= overruns + 8'd1;
            end
          end
          WAIT_VBLANK: begin
            if (frame_start) state <= SWAP;
          end
          SWAP: begin
            disp_bank <= ~disp_bank;
            state     <= CLEAR;
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_controller.sv
// Scoreboard bench for fb_swap_controller: a frame-level model predicts writes and swaps,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fb_swap_controller;
  localparam int HOR    = 4;
  localparam int VER    = 2;
  localparam int PIXELS = HOR * VER;
  localparam int AW     = $clog2(PIXELS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic          frame_start = 1'b0;
  logic          rend_wr_en = 1'b0;
  logic [AW-1:0] rend_wr_addr = '0;
  logic          rend_wr_data = 1'b0;
  logic          rend_done = 1'b0;
  logic          swap;
  logic          fb_wr_en;
  logic [AW:0]   fb_wr_addr;
  logic          fb_wr_data;
  logic          disp_bank;
  logic [7:0]    overruns;

  fb_swap_controller #(
    .HOR_ACTIVE_PIXELS(HOR),
    .VER_ACTIVE_PIXELS(VER),
    .CLEAR_VALUE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start),
    .rend_wr_en(rend_wr_en), .rend_wr_addr(rend_wr_addr), .rend_wr_data(rend_wr_data),
    .rend_done(rend_done), .swap(swap), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .disp_bank(disp_bank), .overruns(overruns)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wr_q[$];
  int  swap_q[$];
  int  cyc_no = 0;
  int  n_vec  = 0;
  int  n_err  = 0;

  // Frame-level reference: pixels still to clear, frame in progress, frame finished, swap due.
  int  m_clear_left;
  bit  m_open;
  bit  m_ready;
  bit  m_swap_due;
  bit  m_disp;
  int  m_over;

  wr_t mon_w;
  int  mon_s;

  always @(posedge clk) cyc_no++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic void model_reset();
    m_clear_left = PIXELS;
    m_open       = 1'b0;
    m_ready      = 1'b0;
    m_swap_due   = 1'b0;
    m_disp       = 1'b0;
    m_over       = 0;
    wr_q.delete();
    swap_q.delete();
  endfunction

  function automatic void model_step(input bit fs, input bit we, input int wa, input bit wd,
                                     input bit dn);
    int  nc   = cyc_no + 1;
    int  base = m_disp ? 0 : PIXELS;
    wr_t w;
    if (m_clear_left > 0) begin
      w = '{nc, base + (PIXELS - m_clear_left), 0};
      wr_q.push_back(w);
      m_clear_left--;
      if (m_clear_left == 0) begin
        swap_q.push_back(nc);
        m_open = 1'b1;
      end
    end else if (m_open) begin
      if (we) begin
        w = '{nc, base + wa, int'(wd)};
        wr_q.push_back(w);
      end
      if (dn) begin
        m_open = 1'b0;
        if (fs) m_swap_due = 1'b1;
        else    m_ready    = 1'b1;
      end else if (fs && m_over < 255) begin
        m_over++;
      end
    end else if (m_ready) begin
      if (fs) begin
        m_ready    = 1'b0;
        m_swap_due = 1'b1;
      end
    end else if (m_swap_due) begin
      m_swap_due   = 1'b0;
      m_disp       = ~m_disp;
      m_clear_left = PIXELS;
    end
  endfunction

  // One clock of stimulus; returns just after the edge that consumed it.
  task automatic apply_stimulus(input bit c, input bit fs, input bit we, input int wa,
                                input bit wd, input bit dn);
    ce           = c;
    frame_start  = fs;
    rend_wr_en   = we;
    rend_wr_addr = AW'(wa);
    rend_wr_data = wd;
    rend_done    = dn;
    if (c) model_step(fs, we, wa, wd, dn);
    @(posedge clk);
    #1;
    if (!c) begin
      check_output("fb_wr_en_on_ce_low", 32'(fb_wr_en), 0);
      check_output("swap_on_ce_low", 32'(swap), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_state();
    check_output("disp_bank", 32'(disp_bank), 32'(m_disp));
    check_output("overruns", 32'(overruns), 32'(m_over));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_output("reset_swap", 32'(swap), 0);
    check_output("reset_fb_wr_en", 32'(fb_wr_en), 0);
    check_output("reset_fb_wr_addr", 32'(fb_wr_addr), 0);
    check_output("reset_fb_wr_data", 32'(fb_wr_data), 0);
    check_output("reset_disp_bank", 32'(disp_bank), 0);
    check_output("reset_overruns", 32'(overruns), 0);
    ce          = 1'b0;
    frame_start = 1'b0;
    rend_wr_en  = 1'b0;
    rend_done   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: every presented write or swap must match the head of its queue, cycle included.
  always @(negedge clk) begin
    if (rst) begin
      if (swap) begin
        if (swap_q.size() == 0) begin
          check_output("unexpected_swap", 32'(swap), 0);
        end else begin
          mon_s = swap_q.pop_front();
          check_output("swap_cycle", 32'(cyc_no), 32'(mon_s));
        end
      end else if (swap_q.size() > 0 && swap_q[0] <= cyc_no) begin
        mon_s = swap_q.pop_front();
        check_output("missing_swap", 32'(swap), 1);
      end
      if (fb_wr_en) begin
        if (wr_q.size() == 0) begin
          check_output("unexpected_write", 32'(fb_wr_en), 0);
        end else begin
          mon_w = wr_q.pop_front();
          check_output("write_cycle", 32'(cyc_no), 32'(mon_w.cyc));
          check_output("write_addr", 32'(fb_wr_addr), 32'(mon_w.addr));
          check_output("write_data", 32'(fb_wr_data), 32'(mon_w.data));
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc_no) begin
        mon_w = wr_q.pop_front();
        check_output("missing_write", 32'(fb_wr_en), 1);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Initial clear of bank 1, then release the renderer.
    idle(PIXELS);
    check_state();

    // Render write to pixel 5 lands at {1,5}; done, vblank three cycles later, bank swap.
    apply_stimulus(1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    check_state();
    idle(PIXELS);

    // rend_done together with frame_start goes straight to the swap.
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(1);
    check_state();
    idle(PIXELS);

    // Missed vblanks count up and saturate.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_state();
    for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_state();
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    check_state();

    // Clear with ce alternating.
    for (int i = 0; i < 2 * PIXELS; i++) apply_stimulus(i % 2 == 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_state();

    // Reset mid-clear, then mid-render.
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(1);
    idle(4);
    do_reset();
    idle(PIXELS);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    do_reset();
    idle(PIXELS);
    check_state();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, PIXELS - 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      if (i % 250 == 249) check_state();
    end

    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_output("pending_writes", 32'(wr_q.size()), 0);
    check_output("pending_swaps", 32'(swap_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
